// File: rtl/phase_result_arbiter.sv
// Round-robin arbiter that collects phase detector period counts into one valid/ready stream.
// Optional build macro PHASE_ARB_ZERO_DROP_EN drops zero counts (detector timeout markers).
module phase_result_arbiter #(
    parameter int unsigned NCH   = 8,
    parameter int unsigned CNT_W = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NCH-1:0]            ph_valid,
    input  logic [NCH*CNT_W-1:0]      ph_cnt,
    input  logic [NCH-1:0]            ch_en,
    input  logic                      ovr_clr,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(NCH)-1:0]    out_ch,
    output logic [CNT_W-1:0]          out_cnt,
    output logic                      out_ovr,
    output logic [NCH-1:0]            ovr_sticky
);

    localparam int unsigned CH_W = $clog2(NCH);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_hold [NCH];
    logic [NCH-1:0]   r_pending;
    logic [NCH-1:0]   r_lost;
    logic [NCH-1:0]   r_sticky;
    logic [CH_W-1:0]  r_rr_ptr;
    logic             r_out_valid;
    logic [CH_W-1:0]  r_out_ch;
    logic [CNT_W-1:0] r_out_cnt;
    logic             r_out_ovr;

    logic [0:0]       w_state_nxt;
    logic [CNT_W-1:0] w_hold_nxt [NCH];
    logic [NCH-1:0]   w_pending_nxt;
    logic [NCH-1:0]   w_lost_nxt;
    logic [NCH-1:0]   w_sticky_nxt;
    logic [CH_W-1:0]  w_rr_ptr_nxt;
    logic             w_out_valid_nxt;
    logic [CH_W-1:0]  w_out_ch_nxt;
    logic [CNT_W-1:0] w_out_cnt_nxt;
    logic             w_out_ovr_nxt;

    logic [NCH-1:0]   w_req;
    logic [NCH-1:0]   w_cap;
    logic [NCH-1:0]   w_gnt_vec;
    logic             w_gnt_found;
    logic [CH_W-1:0]  w_gnt_idx;
    logic             w_grant;
    int unsigned      w_scan;

    // Disabled channels are neither captured nor eligible for grant.
    always_comb begin
        w_req = r_pending & ch_en;
        w_cap = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
`ifdef PHASE_ARB_ZERO_DROP_EN
            w_cap[i] = ph_valid[i] & ch_en[i] & (|ph_cnt[i*CNT_W +: CNT_W]);
`else
            w_cap[i] = ph_valid[i] & ch_en[i];
`endif
        end
    end

    // First requesting channel at or after rr_ptr, wrapping at NCH.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_scan      = 0;
        for (int unsigned k = 0; k < NCH; k++) begin
            w_scan = 32'(r_rr_ptr) + k;
            if (w_scan >= NCH) begin
                w_scan = w_scan - NCH;
            end
            if (!w_gnt_found && w_req[w_scan]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = CH_W'(w_scan);
            end
        end
    end

    assign w_grant   = (r_state == S_IDLE) && w_gnt_found;
    assign w_gnt_vec = w_grant ? (NCH'(1) << w_gnt_idx) : '0;

    // Arbiter FSM: next state and output word.
    always_comb begin
        w_state_nxt     = r_state;
        w_out_valid_nxt = r_out_valid;
        w_out_ch_nxt    = r_out_ch;
        w_out_cnt_nxt   = r_out_cnt;
        w_out_ovr_nxt   = r_out_ovr;
        w_rr_ptr_nxt    = r_rr_ptr;
        case (r_state)
            S_IDLE: begin
                if (w_gnt_found) begin
                    w_out_valid_nxt = 1'b1;
                    w_out_ch_nxt    = w_gnt_idx;
                    w_out_cnt_nxt   = r_hold[w_gnt_idx];
                    w_out_ovr_nxt   = r_lost[w_gnt_idx];
                    w_state_nxt     = S_SEND;
                end
            end
            S_SEND: begin
                if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_rr_ptr_nxt    = (r_out_ch == CH_W'(NCH - 1)) ? '0 : r_out_ch + CH_W'(1);
                    w_state_nxt     = S_IDLE;
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_out_valid_nxt = 1'b0;
            end
        endcase
    end

    // Per-channel holding/pending/lost; a capture in the grant cycle is not an overrun.
    always_comb begin
        w_pending_nxt = r_pending;
        w_lost_nxt    = r_lost;
        w_sticky_nxt  = ovr_clr ? '0 : r_sticky;
        for (int unsigned i = 0; i < NCH; i++) begin
            w_hold_nxt[i] = r_hold[i];
            if (!ch_en[i]) begin
                w_pending_nxt[i] = 1'b0;
                w_lost_nxt[i]    = 1'b0;
            end else begin
                if (w_gnt_vec[i]) begin
                    w_pending_nxt[i] = 1'b0;
                    w_lost_nxt[i]    = 1'b0;
                end
                if (w_cap[i]) begin
                    w_hold_nxt[i]    = ph_cnt[i*CNT_W +: CNT_W];
                    w_pending_nxt[i] = 1'b1;
                    if (r_pending[i] && !w_gnt_vec[i]) begin
                        w_lost_nxt[i]   = 1'b1;
                        w_sticky_nxt[i] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pending   <= '0;
            r_lost      <= '0;
            r_sticky    <= '0;
            r_rr_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_out_cnt   <= '0;
            r_out_ovr   <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++) begin
                r_hold[i] <= '0;
            end
        end else begin
            r_state     <= w_state_nxt;
            r_pending   <= w_pending_nxt;
            r_lost      <= w_lost_nxt;
            r_sticky    <= w_sticky_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_ch    <= w_out_ch_nxt;
            r_out_cnt   <= w_out_cnt_nxt;
            r_out_ovr   <= w_out_ovr_nxt;
            for (int unsigned i = 0; i < NCH; i++) begin
                r_hold[i] <= w_hold_nxt[i];
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_ch     = r_out_ch;
    assign out_cnt    = r_out_cnt;
    assign out_ovr    = r_out_ovr;
    assign ovr_sticky = r_sticky;

endmodule

// File: tb/tb_phase_result_arbiter.sv
// Directed self-checking bench for phase_result_arbiter (NCH=8, CNT_W=32).
module tb_phase_result_arbiter;

    localparam int unsigned NCH   = 8;
    localparam int unsigned CNT_W = 32;
    localparam int unsigned CH_W  = $clog2(NCH);

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NCH-1:0]       ph_valid;
    logic [NCH*CNT_W-1:0] ph_cnt;
    logic [NCH-1:0]       ch_en;
    logic                 ovr_clr;
    logic                 out_valid;
    logic                 out_ready;
    logic [CH_W-1:0]      out_ch;
    logic [CNT_W-1:0]     out_cnt;
    logic                 out_ovr;
    logic [NCH-1:0]       ovr_sticky;

    int n_checks = 0;
    int n_fail   = 0;

    phase_result_arbiter #(.NCH(NCH), .CNT_W(CNT_W)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ph_valid   (ph_valid),
        .ph_cnt     (ph_cnt),
        .ch_en      (ch_en),
        .ovr_clr    (ovr_clr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ch     (out_ch),
        .out_cnt    (out_cnt),
        .out_ovr    (out_ovr),
        .ovr_sticky (ovr_sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cnt(input int ch, input logic [CNT_W-1:0] val);
        ph_cnt[ch*CNT_W +: CNT_W] = val;
    endtask

    task automatic strobe(input int ch, input logic [CNT_W-1:0] val);
        ph_valid     = '0;
        ph_valid[ch] = 1'b1;
        set_cnt(ch, val);
        tick();
        ph_valid = '0;
    endtask

    task automatic check_word(input string tag, input int ch, input logic [CNT_W-1:0] cnt, input logic ovr);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_ch"},    64'(out_ch),    64'(ch));
        check({tag, "_cnt"},   64'(out_cnt),   64'(cnt));
        check({tag, "_ovr"},   64'(out_ovr),   64'(ovr));
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        ph_valid  = '0;
        ph_cnt    = '0;
        ch_en     = '1;
        ovr_clr   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        apply_reset();
        check("rst_valid",  64'(out_valid),  64'd0);
        check("rst_ch",     64'(out_ch),     64'd0);
        check("rst_cnt",    64'(out_cnt),    64'd0);
        check("rst_ovr",    64'(out_ovr),    64'd0);
        check("rst_sticky", 64'(ovr_sticky), 64'd0);

        // Single strobe, one-clock latency, handshake drops valid next cycle.
        out_ready = 1'b1;
        strobe(3, 32'h0001_86A0);
        check("lat_pre", 64'(out_valid), 64'd0);
        tick();
        check_word("lat", 3, 32'h0001_86A0, 1'b0);
        tick();
        check("lat_done", 64'(out_valid), 64'd0);

        // All eight channels at once: round robin from ch0, one word per two clocks.
        apply_reset();
        out_ready = 1'b1;
        ph_valid  = '1;
        for (int i = 0; i < 8; i++) set_cnt(i, 32'(i + 1));
        tick();
        ph_valid = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_word($sformatf("rr%0d", i), i, 32'(i + 1), 1'b0);
            tick();
            check($sformatf("rr%0d_gap", i), 64'(out_valid), 64'd0);
        end

        // Overrun while stalled behind a ch0 word.
        apply_reset();
        strobe(0, 32'd99);
        tick();
        check_word("ovr_c0", 0, 32'd99, 1'b0);
        strobe(2, 32'd10);
        strobe(2, 32'd20);
        strobe(5, 32'd7);
        check("ovr_sticky_set", 64'(ovr_sticky), 64'h04);
        check_word("ovr_hold", 0, 32'd99, 1'b0);
        out_ready = 1'b1;
        tick();
        check("ovr_hs0", 64'(out_valid), 64'd0);
        tick();
        check_word("ovr_c2", 2, 32'd20, 1'b1);
        tick();
        tick();
        check_word("ovr_c5", 5, 32'd7, 1'b0);
        tick();
        check("ovr_end", 64'(out_valid), 64'd0);
        check("ovr_sticky_keep", 64'(ovr_sticky), 64'h04);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check("ovr_sticky_clr", 64'(ovr_sticky), 64'h00);

        // Disabled channel: strobe ignored, and a pending result is discarded on disable.
        apply_reset();
        out_ready = 1'b1;
        ch_en     = 8'hFD;
        strobe(1, 32'd5);
        tick();
        check("dis_ign0", 64'(out_valid), 64'd0);
        tick();
        check("dis_ign1", 64'(out_valid), 64'd0);
        ch_en     = '1;
        out_ready = 1'b0;
        strobe(0, 32'd1);
        tick();
        check_word("dis_c0", 0, 32'd1, 1'b0);
        strobe(1, 32'd6);
        ch_en = 8'hFD;
        tick();
        ch_en     = '1;
        out_ready = 1'b1;
        tick();
        check("dis_hs", 64'(out_valid), 64'd0);
        tick();
        check("dis_drop0", 64'(out_valid), 64'd0);
        tick();
        check("dis_drop1", 64'(out_valid), 64'd0);

        // Reset asserted mid-transfer discards the held word.
        apply_reset();
        strobe(6, 32'h55);
        tick();
        check_word("mrst_c6", 6, 32'h55, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_valid", 64'(out_valid), 64'd0);
        check("mrst_cnt",   64'(out_cnt),   64'd0);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("mrst_quiet%0d", i), 64'(out_valid), 64'd0);
        end
        strobe(6, 32'h77);
        tick();
        check_word("mrst_new", 6, 32'h77, 1'b0);

        // Zero count handling depends on the build option.
        apply_reset();
        out_ready = 1'b1;
        strobe(4, 32'd0);
        tick();
`ifdef PHASE_ARB_ZERO_DROP_EN
        check("zero_drop", 64'(out_valid), 64'd0);
`else
        check_word("zero_fwd", 4, 32'd0, 1'b0);
`endif
        tick();
        check("zero_end", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
